// File: rtl/stream_transpose_pkg.sv
// Shared definitions for the element-serial matrix transposer:
// state encoding, a width helper and the flat buffer index.
package stream_transpose_pkg;

    typedef enum logic {
        ST_FILL  = 1'b0,
        ST_DRAIN = 1'b1
    } state_t;

    function automatic int clog2(input int value);
        int w;
        w = 0;
        while ((1 << w) < value) begin
            w = w + 1;
        end
        return w;
    endfunction

    function automatic int idx(input int row, input int col, input int cols);
        return row * cols + col;
    endfunction

endpackage

// File: rtl/stream_transpose_matrix_index_counter.sv
// Two-level wrapping (row, col) counter; col is the fast index and
// both wrap to zero after (ROWS-1, COLS-1).
module matrix_index_counter
    import stream_transpose_pkg::*;
#(
    parameter int ROWS = 2,
    parameter int COLS = 2,
    localparam int RW = clog2((ROWS > 2) ? ROWS : 2),
    localparam int CW = clog2((COLS > 2) ? COLS : 2)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr,
    input  logic          inc,
    output logic [RW-1:0] row,
    output logic [CW-1:0] col,
    output logic          last
);

    logic [RW-1:0] r_row;
    logic [CW-1:0] r_col;
    logic          w_row_end;
    logic          w_col_end;

    assign w_row_end = (r_row == RW'(ROWS - 1));
    assign w_col_end = (r_col == CW'(COLS - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_row <= '0;
            r_col <= '0;
        end else if (clr) begin
            r_row <= '0;
            r_col <= '0;
        end else if (inc) begin
            if (w_col_end) begin
                r_col <= '0;
                r_row <= w_row_end ? '0 : r_row + 1'b1;
            end else begin
                r_col <= r_col + 1'b1;
            end
        end
    end

    assign row  = r_row;
    assign col  = r_col;
    assign last = w_row_end && w_col_end;

endmodule

// File: rtl/stream_transpose.sv
// Element-serial MxN -> NxM transposer: fills a register buffer in
// row-major order, then drains it column-major.
//   state    | meaning
//   ST_FILL  | accepting input elements, output idle
//   ST_DRAIN | presenting transposed elements, input blocked
module stream_transpose
    import stream_transpose_pkg::*;
#(
    parameter int M          = 2,
    parameter int N          = 2,
    parameter int DATA_WIDTH = 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_WIDTH-1:0] in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last
);

    localparam int RW = clog2((M > 2) ? M : 2);
    localparam int CW = clog2((N > 2) ? N : 2);
    localparam int AW = clog2(((M * N) > 2) ? (M * N) : 2);

    state_t r_state;
    state_t w_state_nxt;

    logic [DATA_WIDTH-1:0] r_buf [M*N];

    logic [RW-1:0] w_wr_row;
    logic [CW-1:0] w_wr_col;
    logic          w_wr_last;
    logic [CW-1:0] w_rd_i;
    logic [RW-1:0] w_rd_j;
    logic          w_rd_last;
    logic          w_wr_en;
    logic          w_rd_en;
    logic [AW-1:0] w_wr_addr;
    logic [AW-1:0] w_rd_addr;

    assign in_ready  = (r_state == ST_FILL) && !rst;
    assign out_valid = (r_state == ST_DRAIN);
    assign out_last  = out_valid && w_rd_last;
    assign w_wr_en   = in_valid && in_ready;
    assign w_rd_en   = out_valid && out_ready;

    // Both counters wrap on their own final step, so no explicit clear is needed.
    matrix_index_counter #(.ROWS(M), .COLS(N)) u_wr_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (1'b0),
        .inc  (w_wr_en),
        .row  (w_wr_row),
        .col  (w_wr_col),
        .last (w_wr_last)
    );

    matrix_index_counter #(.ROWS(N), .COLS(M)) u_rd_cnt (
        .clk  (clk),
        .rst  (rst),
        .clr  (1'b0),
        .inc  (w_rd_en),
        .row  (w_rd_i),
        .col  (w_rd_j),
        .last (w_rd_last)
    );

    assign w_wr_addr = AW'(idx(int'(w_wr_row), int'(w_wr_col), N));
    assign w_rd_addr = AW'(idx(int'(w_rd_j), int'(w_rd_i), N));

    always_ff @(posedge clk) begin
        if (w_wr_en) begin
            r_buf[w_wr_addr] <= in_data;
        end
    end

    assign out_data = r_buf[w_rd_addr];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_FILL;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_FILL:  if (w_wr_en && w_wr_last) w_state_nxt = ST_DRAIN;
            ST_DRAIN: if (w_rd_en && w_rd_last) w_state_nxt = ST_FILL;
            default:  w_state_nxt = ST_FILL;
        endcase
    end

endmodule

// File: tb/tb_stream_transpose.sv
// Scoreboard bench for stream_transpose: a 2x3 instance for the main
// scenarios and a 1x1 instance for the degenerate pass-through case.
module tb_stream_transpose;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic       in_valid, in_ready, out_valid, out_ready, out_last;
    logic [3:0] in_data, out_data;
    logic       in1_valid, in1_ready, out1_valid, out1_ready, out1_last;
    logic [3:0] in1_data, out1_data;

    stream_transpose #(.M(2), .N(3), .DATA_WIDTH(4)) u_dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .out_last(out_last)
    );

    stream_transpose #(.M(1), .N(1), .DATA_WIDTH(4)) u_dut1 (
        .clk(clk), .rst(rst),
        .in_valid(in1_valid), .in_ready(in1_ready), .in_data(in1_data),
        .out_valid(out1_valid), .out_ready(out1_ready), .out_data(out1_data),
        .out_last(out1_last)
    );

    int n_tests = 0;
    int n_fail  = 0;
    logic [4:0] q0[$];
    logic [4:0] q1[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor for the 2x3 instance: pops expected {last,data} per handshake
    // and checks outputs hold while stalled.
    logic       stall_v = 1'b0;
    logic [4:0] stall_d;
    always @(negedge clk) begin
        logic [4:0] e;
        if (rst) begin
            stall_v = 1'b0;
        end else begin
            if (stall_v)
                check("stall_hold", {27'd0, out_valid, out_last, out_data}, {27'd0, 1'b1, stall_d});
            if (out_valid && out_ready) begin
                if (q0.size() == 0) begin
                    n_tests++;
                    n_fail++;
                    $display("FAIL unexpected_out: got %0h, expected no output at %0t", out_data, $time);
                end else begin
                    e = q0.pop_front();
                    check("out_2x3", {27'd0, out_last, out_data}, {27'd0, e});
                end
            end
            stall_v = out_valid && !out_ready;
            stall_d = {out_last, out_data};
        end
    end

    always @(negedge clk) begin
        logic [4:0] e;
        if (!rst && out1_valid && out1_ready) begin
            if (q1.size() == 0) begin
                n_tests++;
                n_fail++;
                $display("FAIL unexpected_out1: got %0h, expected no output at %0t", out1_data, $time);
            end else begin
                e = q1.pop_front();
                check("out_1x1", {27'd0, out1_last, out1_data}, {27'd0, e});
            end
        end
    end

    task automatic push_exp(input int e[6]);
        for (int k = 0; k < 6; k++)
            q0.push_back({(k == 5) ? 1'b1 : 1'b0, 4'(e[k])});
    endtask

    // Presents one element and returns #1 after the edge that accepted it;
    // in_valid is left high so callers can stream without bubbles.
    task automatic send_elem(input int d);
        int g;
        g = 0;
        in_valid = 1'b1;
        in_data  = 4'(d);
        while (!in_ready && g < 100) begin
            @(posedge clk); #1;
            g++;
        end
        if (g >= 100) begin
            n_tests++;
            n_fail++;
            $display("FAIL send_timeout: in_ready stuck low, expected 1");
        end
        @(posedge clk); #1;
    endtask

    task automatic send_mat(input int first, input int gap);
        for (int k = 0; k < 6; k++) begin
            send_elem(first + k);
            if (gap > 0) begin
                in_valid = 1'b0;
                repeat (gap) begin @(posedge clk); #1; end
            end
        end
        in_valid = 1'b0;
    endtask

    task automatic drain(input bit bp);
        for (int k = 0; k < 200 && q0.size() != 0; k++) begin
            out_ready = bp ? ((k % 3) == 0) : 1'b1;
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        check("drain_done_left", q0.size(), 0);
    endtask

    initial begin
        in_valid = 1'b0; in_data = '0; out_ready = 1'b1;
        in1_valid = 1'b0; in1_data = '0; out1_ready = 1'b1;

        // Reset state
        #12;
        check("rst_in_ready", {31'd0, in_ready}, 0);
        check("rst_out_valid", {31'd0, out_valid}, 0);
        check("rst_out_last", {31'd0, out_last}, 0);
        #1 rst = 1'b0;
        #1 check("post_rst_in_ready", {31'd0, in_ready}, 1);
        @(posedge clk); #1;

        // Basic: consecutive output, in_ready back the cycle after last output
        push_exp('{1, 4, 2, 5, 3, 6});
        send_mat(1, 0);
        check("basic_latency_valid", {31'd0, out_valid}, 1);
        check("basic_in_ready_low", {31'd0, in_ready}, 0);
        repeat (6) begin @(posedge clk); #1; end
        check("basic_consecutive", q0.size(), 0);
        check("basic_in_ready_back", {31'd0, in_ready}, 1);
        check("basic_valid_drop", {31'd0, out_valid}, 0);

        // Backpressure
        push_exp('{1, 4, 2, 5, 3, 6});
        send_mat(1, 0);
        drain(1'b1);

        // Input gaps, then in_valid with 15 during DRAIN is ignored
        push_exp('{1, 4, 2, 5, 3, 6});
        send_mat(1, 2);
        out_ready = 1'b0;
        in_valid = 1'b1; in_data = 4'd15;
        repeat (3) begin @(posedge clk); #1; end
        check("drain_in_ready_low", {31'd0, in_ready}, 0);
        in_valid = 1'b0;
        drain(1'b0);

        // Reset mid-fill with no clock edge during the pulse
        for (int k = 0; k < 4; k++) send_elem(1 + k);
        in_valid = 1'b0;
        #1 rst = 1'b1;
        #1 check("midrst_in_ready", {31'd0, in_ready}, 0);
        check("midrst_out_valid", {31'd0, out_valid}, 0);
        #1 rst = 1'b0;
        #1 check("midrst_release_ready", {31'd0, in_ready}, 1);
        @(posedge clk); #1;
        push_exp('{7, 10, 8, 11, 9, 12});
        send_mat(7, 0);
        drain(1'b0);

        // Back-to-back with in_valid held high across the turnaround
        push_exp('{1, 4, 2, 5, 3, 6});
        push_exp('{9, 12, 10, 13, 11, 14});
        for (int k = 0; k < 6; k++) send_elem(1 + k);
        for (int k = 0; k < 6; k++) send_elem(9 + k);
        in_valid = 1'b0;
        drain(1'b0);

        // Degenerate 1x1: one-cycle latency, out_last on every element
        q1.push_back({1'b1, 4'd5});
        q1.push_back({1'b1, 4'd9});
        in1_valid = 1'b1; in1_data = 4'd5;
        @(posedge clk); #1;
        in1_valid = 1'b0;
        check("deg_valid_a", {31'd0, out1_valid}, 1);
        check("deg_data_a", {28'd0, out1_data}, 5);
        check("deg_last_a", {31'd0, out1_last}, 1);
        @(posedge clk); #1;
        check("deg_ready_back", {31'd0, in1_ready}, 1);
        in1_valid = 1'b1; in1_data = 4'd9;
        @(posedge clk); #1;
        in1_valid = 1'b0;
        check("deg_data_b", {28'd0, out1_data}, 9);
        @(posedge clk); #1;
        check("deg_outputs_left", q1.size(), 0);

        repeat (3) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
